// File: rtl/btn_conditioner.sv
// Multi-button front end: 2-flop synchroniser, tick-sampled debounce,
// registered level plus rise/fall/auto-repeat one-clock pulses.
module btn_conditioner #(
    parameter int N_BTN        = 3,
    parameter int TICK_DIV     = 131072,
    parameter int DB_CNT       = 3,
    parameter int HOLD_TICKS   = 382,
    parameter int REPEAT_TICKS = 76
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic             tick,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam bit REPEAT_EN = (HOLD_TICKS > 0);

    localparam logic [PW-1:0] PRE_MAX     = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX      = DW'(DB_CNT - 1);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_TICKS - REPEAT_TICKS);

    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_q, tick_d;
    logic [DW-1:0]    db_cnt_q [N_BTN];
    logic [DW-1:0]    db_cnt_d [N_BTN];
    logic [HW-1:0]    hold_cnt_q [N_BTN];
    logic [HW-1:0]    hold_cnt_d [N_BTN];
    logic [N_BTN-1:0] stable_q, stable_d;
    logic [N_BTN-1:0] rise_q, rise_d;
    logic [N_BTN-1:0] fall_q, fall_d;
    logic [N_BTN-1:0] rep_q, rep_d;

    always_comb begin
        sync1_d    = btn_in;
        sync2_d    = sync1_q;
        tick_d     = (presc_q == PRE_MAX);
        presc_d    = tick_d ? '0 : presc_q + PW'(1);
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        stable_d   = stable_q;
        rise_d     = '0;
        fall_d     = '0;
        rep_d      = '0;
        if (tick_q) begin
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    db_cnt_d[i] = '0;
                end else if (db_cnt_q[i] == DB_MAX) begin
                    stable_d[i] = sync2_q[i];
                    db_cnt_d[i] = '0;
                    rise_d[i]   = sync2_q[i];
                    fall_d[i]   = ~sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                end
                // An accepted release suppresses any repeat due this tick
                if (fall_d[i] || !stable_q[i]) begin
                    hold_cnt_d[i] = '0;
                end else if (REPEAT_EN) begin
                    if (hold_cnt_q[i] + HW'(1) == HOLD_MAX) begin
                        rep_d[i]      = 1'b1;
                        hold_cnt_d[i] = HOLD_RELOAD;
                    end else begin
                        hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            rep_q    <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt_q[i]   <= '0;
                hold_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            stable_q   <= stable_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            rep_q      <= rep_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign tick       = tick_q;
    assign btn_level  = stable_q;
    assign btn_rise   = rise_q;
    assign btn_fall   = fall_q;
    assign btn_repeat = rep_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a tick-counting reference model
// compared every cycle, plus literal expectations per scenario.
module tb_btn_conditioner;

    localparam int N  = 3;
    localparam int TD = 4;
    localparam int DB = 3;
    localparam int HT = 5;
    localparam int RT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_in;
    logic         tick;
    logic [N-1:0] btn_level, btn_rise, btn_fall, btn_repeat;

    btn_conditioner #(
        .N_BTN(N), .TICK_DIV(TD), .DB_CNT(DB),
        .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .tick(tick),
        .btn_level(btn_level), .btn_rise(btn_rise),
        .btn_fall(btn_fall), .btn_repeat(btn_repeat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: decisions taken from tick numbers and sample runs
    bit           m_on = 0;
    int           m_cyc, m_tnum;
    int           m_run [N];
    int           m_acc [N];
    logic [N-1:0] m_h1, m_h2;
    logic         e_tick;
    logic [N-1:0] e_level, e_rise, e_fall, e_rep;

    initial forever begin
        logic         tk, lvl, rel;
        logic [N-1:0] smp;
        int           since;
        @(posedge clk);
        if (rst) begin
            m_on = 1; m_cyc = 0; m_tnum = 0;
            m_h1 = '0; m_h2 = '0;
            e_tick = 0; e_level = '0; e_rise = '0; e_fall = '0; e_rep = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i] = 0;
                m_acc[i] = 0;
            end
        end else if (m_on) begin
            tk  = e_tick;
            smp = m_h2;
            m_h2 = m_h1;
            m_h1 = btn_in;
            m_cyc++;
            e_tick = (m_cyc % TD == 0);
            e_rise = '0; e_fall = '0; e_rep = '0;
            if (tk) begin
                m_tnum++;
                for (int i = 0; i < N; i++) begin
                    lvl = e_level[i];
                    rel = 0;
                    if (smp[i] != lvl) begin
                        m_run[i]++;
                        if (m_run[i] == DB) begin
                            m_run[i] = 0;
                            e_level[i] = smp[i];
                            if (smp[i]) begin
                                e_rise[i] = 1;
                                m_acc[i] = m_tnum;
                            end else begin
                                e_fall[i] = 1;
                                rel = 1;
                            end
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                    if (lvl && !rel && HT > 0) begin
                        since = m_tnum - m_acc[i];
                        if (since >= HT && (since - HT) % RT == 0)
                            e_rep[i] = 1;
                    end
                end
            end
        end
    end

    int rise_cnt [N];
    int fall_cnt [N];
    int rep_cnt  [N];
    int tick_cnt = 0;

    initial begin
        for (int i = 0; i < N; i++) begin
            rise_cnt[i] = 0; fall_cnt[i] = 0; rep_cnt[i] = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_on) begin
            chk("tick", int'(tick), int'(e_tick));
            chk("btn_level", int'(btn_level), int'(e_level));
            chk("btn_rise", int'(btn_rise), int'(e_rise));
            chk("btn_fall", int'(btn_fall), int'(e_fall));
            chk("btn_repeat", int'(btn_repeat), int'(e_rep));
            tick_cnt += int'(tick);
            for (int i = 0; i < N; i++) begin
                rise_cnt[i] += int'(btn_rise[i]);
                fall_cnt[i] += int'(btn_fall[i]);
                rep_cnt[i]  += int'(btn_repeat[i]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_rise(input int b, input int lim,
                             output bit found, output int lat);
        found = 0;
        lat = 0;
        while (!found && lat < lim) begin
            step(1);
            lat++;
            if (btn_rise[b]) found = 1;
        end
    endtask

    task automatic wait_fall(input int b, input int lim,
                             output bit found, output int ticks);
        int n = 0;
        found = 0;
        ticks = 0;
        while (!found && n < lim) begin
            step(1);
            n++;
            if (btn_fall[b]) found = 1;
            else if (tick) ticks++;
        end
    endtask

    initial begin
        bit found;
        int lat, nt, first, t0, r0, r1, r2, f0, f1, f2;
        rst = 1;
        btn_in = '0;
        step(3);
        rst = 0;

        // 1: idle after reset
        t0 = tick_cnt;
        first = -1;
        for (int c = 1; c <= 40; c++) begin
            step(1);
            if (tick && first < 0) first = c;
        end
        chk("s1_first_tick", first, TD);
        chk("s1_tick_count", tick_cnt - t0, 10);
        chk("s1_no_pulses", rise_cnt[0] + rise_cnt[1] + rise_cnt[2]
            + fall_cnt[0] + fall_cnt[1] + fall_cnt[2]
            + rep_cnt[0] + rep_cnt[1] + rep_cnt[2], 0);
        chk("s1_level", int'(btn_level), 0);

        // 2: single press on bit 0
        btn_in[0] = 1;
        wait_rise(0, 20, found, lat);
        chk("s2_rise_found", int'(found), 1);
        chk("s2_lat_ok", int'(lat >= 11 && lat <= 15), 1);
        chk("s2_level0", int'(btn_level[0]), 1);
        step(20);
        chk("s2_one_rise", rise_cnt[0], 1);
        chk("s2_quiet_b12", rise_cnt[1] + rise_cnt[2]
            + fall_cnt[1] + fall_cnt[2], 0);

        // 3: short glitch on bit 1
        r1 = rise_cnt[1];
        f1 = fall_cnt[1];
        btn_in[1] = 1;
        step(6);
        btn_in[1] = 0;
        step(30);
        chk("s3_level1", int'(btn_level[1]), 0);
        chk("s3_no_edges", rise_cnt[1] - r1 + fall_cnt[1] - f1, 0);

        btn_in[0] = 0;
        wait_fall(0, 20, found, nt);
        chk("s3_rel0_found", int'(found), 1);
        step(10);

        // 4: long hold on bit 2 with auto-repeat
        r2 = rise_cnt[2];
        f2 = fall_cnt[2];
        btn_in[2] = 1;
        wait_rise(2, 20, found, lat);
        chk("s4_rise_found", int'(found), 1);
        t0 = rep_cnt[2];
        nt = 0;
        for (int c = 0; c < 300 && nt < 38; c++) begin
            step(1);
            if (tick) nt++;
        end
        chk("s4_ticks_held", nt, 38);
        btn_in[2] = 0;
        wait_fall(2, 30, found, nt);
        chk("s4_fall_found", int'(found), 1);
        chk("s4_fall_ticks", nt, 3);
        chk("s4_repeats", rep_cnt[2] - t0, 18);
        chk("s4_one_rise", rise_cnt[2] - r2, 1);
        chk("s4_one_fall", fall_cnt[2] - f2, 1);
        t0 = rep_cnt[2];
        step(40);
        chk("s4_no_rep_after", rep_cnt[2] - t0, 0);

        // 5: reset in the middle of a hold
        btn_in[0] = 1;
        wait_rise(0, 20, found, lat);
        chk("s5_rise_found", int'(found), 1);
        step(12);
        f0 = fall_cnt[0];
        r0 = rise_cnt[0];
        rst = 1;
        step(1);
        chk("s5_level_rst", int'(btn_level), 0);
        chk("s5_fall_rst", int'(btn_fall), 0);
        chk("s5_tick_rst", int'(tick), 0);
        rst = 0;
        wait_rise(0, 15, found, lat);
        chk("s5_fresh_rise", int'(found), 1);
        chk("s5_no_fall", fall_cnt[0] - f0, 0);
        chk("s5_rise_count", rise_cnt[0] - r0, 1);

        btn_in[0] = 0;
        wait_fall(0, 20, found, nt);
        chk("s5_rel_found", int'(found), 1);
        step(10);

        // 6: simultaneous press and release
        btn_in = '1;
        lat = 0;
        while (btn_rise == '0 && lat < 20) begin
            step(1);
            lat++;
        end
        chk("s6_rise_all", int'(btn_rise), 7);
        step(1);
        chk("s6_rise_1clk", int'(btn_rise), 0);
        step(8);
        btn_in = '0;
        lat = 0;
        while (btn_fall == '0 && lat < 20) begin
            step(1);
            lat++;
        end
        chk("s6_fall_all", int'(btn_fall), 7);
        step(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
